lsu_dmem_port: RTL and testbench

- Load/store unit sitting between the execute stage's address/operand outputs and the data-memory bus.
- Accepts one memory operation at a time: effective address, store data, width/sign code.
- Issues a word-aligned request with byte enables and waits for grant and, for loads, read data.
- Returns the aligned and sign/zero-extended load result, or a store completion, to the write-back stage.

---
 rtl/lsu_dmem_port.sv | 161 ++++++++++++++++
 tb/tb_lsu_dmem_port.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_dmem_port.sv
// Load/store unit: one load/store at a time onto a word bus with byte enables; optional LSU_TIMEOUT_EN watchdog.
// Latency from accept with a zero-wait bus: error response 1 cycle, store 2 cycles, load 3 cycles.
// Backpressure: req_ready is low while an operation is in flight; the completion pulse cannot be stalled.
module lsu_dmem_port #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        memread,
   input  logic        memwrite,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        resp_valid,
   output logic        resp_err,
   output logic [31:0] rdata,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_gnt,
   input  logic        dmem_rvalid,
   input  logic [31:0] dmem_rdata
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

   state_t      state_q, state_d;
   logic [31:0] addr_q, wdata_q, rdata_q;
   logic [2:0]  f3_q;
   logic        we_q, err_q;
   logic        accept, legal, misaligned, timeout;
   logic [3:0]  be;
   logic [31:0] bus_wdata, load_val;
   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   assign accept = (state_q == IDLE) && req_valid && (memread || memwrite);

   always_comb begin
      legal = 1'b0;
      if (memread && memwrite)
         legal = 1'b0;
      else if (memread)
         legal = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      else
         legal = funct3 inside {3'b000, 3'b001, 3'b010};
      misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                   ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
   end

   // Lane steering is driven from the latched operation so the bus stays stable until grant.
   always_comb begin
      be        = 4'b1111;
      bus_wdata = wdata_q;
      case (f3_q[1:0])
         2'b00: begin
            be        = 4'b0001 << addr_q[1:0];
            bus_wdata = {4{wdata_q[7:0]}};
         end
         2'b01: begin
            be        = addr_q[1] ? 4'b1100 : 4'b0011;
            bus_wdata = {2{wdata_q[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      lane_b = dmem_rdata[7:0];
      case (addr_q[1:0])
         2'b01:   lane_b = dmem_rdata[15:8];
         2'b10:   lane_b = dmem_rdata[23:16];
         2'b11:   lane_b = dmem_rdata[31:24];
         default: ;
      endcase
      lane_h = addr_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      case (f3_q)
         3'b000:  load_val = {{24{lane_b[7]}}, lane_b};
         3'b100:  load_val = {24'd0, lane_b};
         3'b001:  load_val = {{16{lane_h[15]}}, lane_h};
         3'b101:  load_val = {16'd0, lane_h};
         default: load_val = dmem_rdata;
      endcase
   end

`ifdef LSU_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= '0;
      else if (accept)
         cnt_q <= '0;
      else if (state_q == REQ || state_q == WAIT)
         cnt_q <= cnt_q + 1'b1;
   end

   assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (accept) state_d = (!legal || misaligned) ? RESP : REQ;
         REQ: begin
            if (dmem_gnt)     state_d = we_q ? RESP : WAIT;
            else if (timeout) state_d = RESP;
         end
         WAIT: if (dmem_rvalid || timeout) state_d = RESP;
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         f3_q    <= '0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            addr_q  <= addr;
            wdata_q <= wdata;
            f3_q    <= funct3;
            we_q    <= memwrite;
            err_q   <= !legal || misaligned;
            rdata_q <= '0;
         end else if (state_q == REQ && !dmem_gnt && timeout) begin
            err_q <= 1'b1;
         end else if (state_q == WAIT) begin
            if (dmem_rvalid)
               rdata_q <= load_val;
            else if (timeout)
               err_q <= 1'b1;
         end
      end
   end

   assign req_ready  = (state_q == IDLE);
   assign resp_valid = (state_q == RESP);
   assign resp_err   = (state_q == RESP) && err_q;
   assign rdata      = rdata_q;
   assign dmem_req   = (state_q == REQ);
   assign dmem_we    = (state_q == REQ) && we_q;
   assign dmem_addr  = {addr_q[31:2], 2'b00};
   assign dmem_be    = (state_q == REQ) ? be : 4'b0000;
   assign dmem_wdata = bus_wdata;

endmodule

// File: tb/tb_lsu_dmem_port.sv
// Randomised and directed bench for lsu_dmem_port against a byte-arithmetic reference model.
module tb_lsu_dmem_port;

`ifdef LSU_TIMEOUT_EN
   localparam int TO = 4;
`else
   localparam int TO = 0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0, memread = 1'b0, memwrite = 1'b0;
   logic [2:0]  funct3 = '0;
   logic [31:0] addr = '0, wdata = '0;
   logic        dmem_gnt = 1'b0, dmem_rvalid = 1'b0;
   logic [31:0] dmem_rdata = '0;
   logic        req_ready, resp_valid, resp_err, dmem_req, dmem_we;
   logic [31:0] rdata, dmem_addr, dmem_wdata;
   logic [3:0]  dmem_be;

   int checks = 0;
   int errors = 0;

   logic        chk_en = 1'b0;
   logic        exp_ready, exp_req, exp_resp, exp_err, exp_we;
   logic [31:0] exp_rdata, exp_addr, exp_wdata;
   logic [3:0]  exp_be;

   lsu_dmem_port #(.TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .memread(memread), .memwrite(memwrite), .funct3(funct3), .addr(addr), .wdata(wdata),
      .resp_valid(resp_valid), .resp_err(resp_err), .rdata(rdata),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
      .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
      .dmem_rdata(dmem_rdata)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int op_size(input logic [2:0] f3);
      return 1 << f3[1:0];
   endfunction

   function automatic logic model_err(input logic rd, input logic wr, input logic [2:0] f3,
                                      input logic [31:0] a);
      if (rd && wr) return 1'b1;
      if (rd && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
      if (wr && f3 > 3'd2) return 1'b1;
      return (a % op_size(f3)) != 0;
   endfunction

   function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
      logic [7:0] m;
      m = ((8'd1 << op_size(f3)) - 8'd1) << (a % 4);
      return m[3:0];
   endfunction

   function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % op_size(f3)) +: 8];
      return r;
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] bus);
      int sz;
      logic [31:0] v, mask;
      sz = op_size(f3);
      v  = bus >> (8 * (a % 4));
      if (sz < 4) begin
         mask = (32'd1 << (8 * sz)) - 32'd1;
         v = v & mask;
         if (!f3[2] && v[8*sz-1]) v = v | ~mask;
      end
      return v;
   endfunction

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         chk("req_ready", {31'd0, req_ready}, {31'd0, exp_ready});
         chk("dmem_req", {31'd0, dmem_req}, {31'd0, exp_req});
         chk("resp_valid", {31'd0, resp_valid}, {31'd0, exp_resp});
         chk("resp_err", {31'd0, resp_err}, {31'd0, exp_err});
         if (exp_resp) chk("rdata", rdata, exp_rdata);
         if (exp_req) begin
            chk("dmem_addr", dmem_addr, exp_addr);
            chk("dmem_be", {28'd0, dmem_be}, {28'd0, exp_be});
            chk("dmem_we", {31'd0, dmem_we}, {31'd0, exp_we});
            if (exp_we) chk("dmem_wdata", dmem_wdata, exp_wdata);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      exp_ready = 1'b1; exp_req = 1'b0; exp_resp = 1'b0; exp_err = 1'b0; exp_rdata = '0;
   endtask

   // gd: REQ cycles before gnt; rvd: WAIT cycles before rvalid
   task automatic run_op(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input int gd, input int rvd, input logic [31:0] bus_rd);
      int  k, j;
      bit  done, tmo;
      req_valid = 1'b1; memread = rd; memwrite = wr; funct3 = f3; addr = a; wdata = wd;
      set_idle();
      step();
      req_valid = 1'b0; memread = 1'($urandom_range(0, 1)); memwrite = 1'($urandom_range(0, 1));
      funct3 = 3'($urandom_range(0, 7)); addr = $urandom; wdata = $urandom;
      if (!rd && !wr) return;
      exp_ready = 1'b0;
      if (model_err(rd, wr, f3, a)) begin
         exp_resp = 1'b1; exp_err = 1'b1; exp_rdata = '0;
         step();
         set_idle();
         return;
      end
      exp_we = wr; exp_addr = {a[31:2], 2'b00};
      exp_be = model_be(f3, a); exp_wdata = model_wdata(f3, wd);
      k = 0; tmo = 0; done = 0;
      while (!done) begin
         exp_req = 1'b1;
         dmem_gnt = (k == gd);
         dmem_rvalid = 1'($urandom_range(0, 1));
         dmem_rdata = $urandom;
         if (k == gd) done = 1;
         else if (TO > 0 && k == TO - 1) begin done = 1; tmo = 1; end
         step();
         k++;
      end
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0; exp_req = 1'b0;
      if (!tmo && !wr) begin
         j = 0; done = 0;
         while (!done) begin
            dmem_rvalid = (j == rvd);
            dmem_rdata = (j == rvd) ? bus_rd : $urandom;
            if (j == rvd) done = 1;
            else if (TO > 0 && k == TO - 1) begin done = 1; tmo = 1; end
            step();
            k++; j++;
         end
         dmem_rvalid = 1'b0;
      end
      exp_resp = 1'b1; exp_err = tmo;
      exp_rdata = (!tmo && !wr) ? model_load(f3, a, bus_rd) : 32'd0;
      dmem_rvalid = tmo;
      dmem_rdata = $urandom;
      step();
      dmem_rvalid = 1'b0;
      set_idle();
   endtask

   function automatic logic [2:0] pick_f3(input logic wr);
      int r;
      r = $urandom_range(0, wr ? 2 : 4);
      case (r)
         0: return 3'd0;
         1: return 3'd1;
         2: return 3'd2;
         3: return 3'd4;
         default: return 3'd5;
      endcase
   endfunction

   initial begin
      logic        rd, wr;
      logic [2:0]  f3;
      logic [31:0] a;
      int          r;

      set_idle();
      exp_we = 1'b0; exp_addr = '0; exp_be = '0; exp_wdata = '0;
      #3;
      chk("rst_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_resp", {30'd0, resp_valid, resp_err}, 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_bus", {29'd0, dmem_req, dmem_we, |dmem_be}, 32'd0);
      chk("rst_addr", dmem_addr, 32'd0);
      chk("rst_wdata", dmem_wdata, 32'd0);
      step();
      rst_n = 1'b1;
      chk_en = 1'b1;
      step();

      chk("pin_sb_be", {28'd0, model_be(3'd0, 32'h1003)}, 32'h8);
      chk("pin_sb_wd", model_wdata(3'd0, 32'hAABBCCDD), 32'hDDDDDDDD);
      chk("pin_sh_be", {28'd0, model_be(3'd1, 32'h1002)}, 32'hC);
      chk("pin_lb", model_load(3'd0, 32'h2002, 32'h12F45678), 32'hFFFFFFF4);
      chk("pin_lbu", model_load(3'd4, 32'h2002, 32'h12F45678), 32'h000000F4);
      chk("pin_lh", model_load(3'd1, 32'h2002, 32'h80010000), 32'hFFFF8001);
      chk("pin_lw_err", {31'd0, model_err(1'b1, 1'b0, 3'd2, 32'h2001)}, 32'd1);

      run_op(1'b0, 1'b1, 3'd0, 32'h1003, 32'hAABBCCDD, 0, 0, 32'd0);
      run_op(1'b1, 1'b0, 3'd0, 32'h2002, 32'd0, 0, 0, 32'h12F45678);
      run_op(1'b1, 1'b0, 3'd4, 32'h2002, 32'd0, 0, 0, 32'h12F45678);
      run_op(1'b1, 1'b0, 3'd1, 32'h2002, 32'd0, 0, 0, 32'h80010000);
      run_op(1'b1, 1'b0, 3'd2, 32'h2001, 32'd0, 0, 0, 32'd0);
      run_op(1'b0, 1'b1, 3'd1, 32'h1002, 32'h11223344, 4, 0, 32'd0);
      run_op(1'b1, 1'b1, 3'd2, 32'h1000, 32'd0, 0, 0, 32'd0);
      run_op(1'b0, 1'b0, 3'd2, 32'h1000, 32'd0, 0, 0, 32'd0);
      run_op(1'b1, 1'b0, 3'd2, 32'h3000, 32'd0, 60, 0, 32'hDEADBEEF);

      // reset while waiting for read data
      req_valid = 1'b1; memread = 1'b1; memwrite = 1'b0; funct3 = 3'd2; addr = 32'h4000;
      set_idle();
      step();
      req_valid = 1'b0;
      exp_ready = 1'b0; exp_req = 1'b1; exp_we = 1'b0; exp_addr = 32'h4000; exp_be = 4'hF;
      dmem_gnt = 1'b1;
      step();
      dmem_gnt = 1'b0; exp_req = 1'b0;
      #2; chk_en = 1'b0; rst_n = 1'b0; #1;
      chk("rstwait_req", {31'd0, dmem_req}, 32'd0);
      chk("rstwait_resp", {31'd0, resp_valid}, 32'd0);
      chk("rstwait_ready", {31'd0, req_ready}, 32'd1);
      step();
      rst_n = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'h55AA55AA;
      set_idle(); chk_en = 1'b1;
      step();
      dmem_rvalid = 1'b0;
      step();

      // reset while requesting: dmem_req must drop without a clock edge
      req_valid = 1'b1; memread = 1'b0; memwrite = 1'b1; funct3 = 3'd2; addr = 32'h5000;
      step();
      req_valid = 1'b0;
      #2; chk_en = 1'b0;
      chk("rstreq_pre", {31'd0, dmem_req}, 32'd1);
      rst_n = 1'b0; #1;
      chk("rstreq_req", {31'd0, dmem_req}, 32'd0);
      chk("rstreq_ready", {31'd0, req_ready}, 32'd1);
      step();
      rst_n = 1'b1; set_idle(); chk_en = 1'b1;
      step();

      for (int n = 0; n < 300; n++) begin
         r = $urandom_range(0, 19);
         rd = (r < 9) || (r == 18);
         wr = (r >= 9 && r < 18) || (r == 18);
         f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : pick_f3(wr);
         a = $urandom;
         if ($urandom_range(0, 9) < 7) begin
            if (f3[1:0] == 2'b01) a[0] = 1'b0;
            if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
         end
         run_op(rd, wr, f3, a, $urandom,
                ($urandom_range(0, 7) == 0) ? $urandom_range(0, 6) : $urandom_range(0, 2),
                ($urandom_range(0, 7) == 0) ? $urandom_range(0, 6) : $urandom_range(0, 2),
                $urandom);
         repeat ($urandom_range(0, 2)) begin
            dmem_rvalid = 1'($urandom_range(0, 1));
            step();
         end
         dmem_rvalid = 1'b0;
      end

      step();
      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
